mul_div_unit: RTL
=================

# mul_div_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It sits beside the single-cycle ALU in the EX stage. It accepts one operation per start pulse and holds `busy` while it iterates. The pipeline stalls any HI/LO consumer while `busy` is high and can cancel an in-flight operation through `flush`.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. Must be at least 4.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: launch `op`; sampled only while `busy`=0.
- `op`, in, 3: operation code, values from the shared macro header.
- `SrcA`, in, WIDTH: multiplicand / dividend / MTHI-MTLO data.
- `SrcB`, in, WIDTH: multiplier / divisor.
- `flush`, in, 1: cancel the in-flight operation.
- `busy`, out, 1: iteration in progress.
- `done`, out, 1: one-cycle pulse after HI/LO are written by MULT/DIV.
- `HI`, out, WIDTH: high product / remainder.
- `LO`, out, WIDTH: low product / quotient.

## Operation
- Op codes: `MD_MULT`=0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3, `MD_MTHI`=4, `MD_MTLO`=5. Codes 6 and 7 are no-ops.
- FSM states:
  - IDLE → RUN on `start` with a MULT/DIV op.
  - RUN holds for WIDTH cycles, then → FIX.
  - FIX → IDLE, writing HI/LO.
  - `flush` in RUN or FIX → IDLE, with no write.
- On start, latch the operands as magnitudes for signed ops, and latch the result signs.
  - Product sign = sign(A) XOR sign(B).
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- RUN:
  - Multiply: radix-2 shift-add, one multiplier bit per cycle, 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX applies the two's-complement sign correction and writes HI/LO.
- Arithmetic rules:
  - MULT/MULTU: {HI,LO} = full 2·WIDTH product.
  - DIV/DIVU: quotient truncated toward zero in LO, remainder in HI.
- Divide by zero (DIV or DIVU): LO = all ones, HI = SrcA unchanged.
- Signed overflow (DIV with SrcA = MIN and SrcB = −1): LO = MIN, HI = 0.
- MTHI/MTLO:
  - With `busy`=0: write the register on the same edge. `busy` stays 0 and `done` does not pulse.
  - With `busy`=1: ignored, like any other start.
- `start` while `busy`=1: ignored. No queueing.
- Same edge carries `flush` and a start while idle: `flush` wins and the start is dropped.
- Reset values: `busy`=0, `done`=0, `HI`=0, `LO`=0, FSM=IDLE.
- Reset mid-operation aborts immediately to the reset values.

## Timing
- Start accepted at edge E0:
  - `busy` rises after E0.
  - RUN covers edges E1..E(WIDTH).
  - FIX writes HI/LO at E(WIDTH+1); `busy` falls at the same edge.
  - `done` is high from E(WIDTH+1) to E(WIDTH+2).
- Total latency is WIDTH+1 cycles, i.e. 33 for WIDTH=32.
- A new start is accepted at E(WIDTH+1) at the earliest, because `busy` is sampled as 0 there.
- HI/LO are registered outputs and change only on a FIX write, an MTHI/MTLO write, or reset.
- `flush` at any edge during `busy`: `busy`=0 after that edge, HI/LO keep their old values, no `done`.

## Structure
- Shared macro header (`macro.vh`) holds:
  - the `MD_*` op codes;
  - a `MD_OP` 3-bit width define;
  - the FSM state encodings `MDS_IDLE`, `MDS_RUN`, `MDS_FIX`.
- One sub-module, `md_iter_core`, holds the per-cycle shift-add / restoring step, the accumulator and the iteration counter.
- The top level holds:
  - the FSM;
  - operand latching and sign handling;
  - the special cases;
  - the HI/LO registers.

## Test plan
All cases use WIDTH=32.
- MULT A=0xFFFFFFFD, B=5 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1, `done` high one cycle.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. DIV A=0xFFFFFFF9, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Special cases:
  - DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=7.
  - DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIVU 100/7 and assert `flush` at cycle 10 → `busy` low next cycle, HI/LO keep their prior values, no `done`. Start MULT again while busy → ignored, `busy` low at E33.
- MTHI 0x12345678 while idle → HI updated at the same edge, `busy` stays 0, LO unchanged.
- `reset_n` low mid-RUN at cycle 5 → `busy`, `done`, HI, LO all 0 asynchronously; the next start runs a full 33 cycles.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state encodings and small helpers for the multi-cycle
// multiply/divide unit.
package mul_div_unit_pkg;

  localparam int MD_OP = 3;

  localparam logic [MD_OP-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP-1:0] MD_MTLO  = 3'd5;

  localparam logic [1:0] MDS_IDLE = 2'd0;
  localparam logic [1:0] MDS_RUN  = 2'd1;
  localparam logic [1:0] MDS_FIX  = 2'd2;

  // Iterating ops are exactly the codes with bit 2 clear.
  function automatic logic is_iter_op(input logic [MD_OP-1:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_signed_op(input logic [MD_OP-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-side bus of the multiply/divide unit: launch request, flush,
// status and the HI/LO result registers.
interface mul_div_unit_if #(parameter int WIDTH = 32) ();
  import mul_div_unit_pkg::*;

  // start is a request sampled only when busy is low; there is no ready
  // handshake beyond busy, and a start seen while busy is simply dropped.
  logic             start;
  logic [MD_OP-1:0] op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, SrcA, SrcB, flush,
    input  busy, done, HI, LO, dbg_state
  );

  modport slave (
    input  start, op, SrcA, SrcB, flush,
    output busy, done, HI, LO, dbg_state
  );

endinterface

// File: rtl/mul_div_unit_md_iter_core.sv
// Per-cycle datapath: radix-2 shift-add multiply or restoring divide over a
// 2*WIDTH accumulator, plus the iteration counter.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_mag_i,
  input  logic [WIDTH-1:0]   b_mag_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               last_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;

  // Multiply keeps {partial_hi, multiplier} in acc; divide keeps {rem, quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, opnd_q};
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      is_div_d = is_div_i;
      opnd_d   = is_div_i ? b_mag_i : a_mag_i;
      acc_d    = {{WIDTH{1'b0}}, (is_div_i ? a_mag_i : b_mag_i)};
      cnt_d    = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        // Bit WIDTH of the difference is the borrow: set means restore.
        if (!rem_diff[WIDTH])
          acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: FSM, operand sign handling, special
// cases and the HI/LO registers around the iterative core.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset_n,
  mul_div_unit_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               is_div_q, q_neg_q, r_neg_q, dz_q, ovf_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               accept, launch, write_fix;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc;
  logic               last;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;

  // A flush on the same edge as an idle start drops the start.
  assign accept    = bus.start && !bus.flush && (state_q == MDS_IDLE);
  assign launch    = accept && is_iter_op(bus.op);
  assign write_fix = (state_q == MDS_FIX) && !bus.flush;

  assign a_neg = is_signed_op(bus.op) && bus.SrcA[WIDTH-1];
  assign b_neg = is_signed_op(bus.op) && bus.SrcB[WIDTH-1];
  assign a_mag = a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
  assign b_mag = b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (launch),
    .step_i   ((state_q == MDS_RUN) && !bus.flush),
    .is_div_i (bus.op[1]),
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .acc_o    (acc),
    .last_o   (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDS_IDLE: if (launch) state_d = MDS_RUN;
      MDS_RUN:  begin
        if (bus.flush)  state_d = MDS_IDLE;
        else if (last)  state_d = MDS_FIX;
      end
      MDS_FIX:  state_d = MDS_IDLE;
      default:  state_d = MDS_IDLE;
    endcase
  end

  // q_neg_q doubles as the product sign for multiplies.
  always_comb begin
    prod = q_neg_q ? (~acc + 1'b1) : acc;
    quot = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      if (dz_q) begin
        fix_lo = '1;
        fix_hi = a_raw_q;
      end else if (ovf_q) begin
        fix_lo = MIN_VAL;
        fix_hi = '0;
      end else begin
        fix_lo = q_neg_q ? (~quot + 1'b1) : quot;
        fix_hi = r_neg_q ? (~rem + 1'b1) : rem;
      end
    end else begin
      fix_lo = prod[WIDTH-1:0];
      fix_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = write_fix;
    if (write_fix) begin
      hi_d = fix_hi;
      lo_d = fix_lo;
    end else if (accept && (bus.op == MD_MTHI)) begin
      hi_d = bus.SrcA;
    end else if (accept && (bus.op == MD_MTLO)) begin
      lo_d = bus.SrcA;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MDS_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      a_raw_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      if (launch) begin
        is_div_q <= bus.op[1];
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
        dz_q     <= bus.op[1] && (bus.SrcB == '0);
        ovf_q    <= (bus.op == MD_DIV) && (bus.SrcA == MIN_VAL) && (bus.SrcB == '1);
        a_raw_q  <= bus.SrcA;
      end
    end
  end

  assign bus.busy      = (state_q != MDS_IDLE);
  assign bus.done      = done_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.dbg_state = state_q;

endmodule
